// File: rtl/unitate_control_multiciclu_if.sv
// Control-unit bus bundle: instruction/data handshake inputs and datapath/memory control outputs.
// The control unit takes the master side; the datapath/memory model takes the slave side.
interface unitate_control_multiciclu_if #(
  parameter int OPCODE_W   = 4,
  parameter int ALU_CTRL_W = 4
);
  logic [OPCODE_W-1:0]   opcode;
  logic                  mem_ack;
  logic                  zero_flag;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_load;
  logic                  pc_inc;
  logic                  pc_load;
  logic                  halted;
  logic                  illegal;
  logic                  bus_err;

  modport master (
    input  opcode, mem_ack, zero_flag,
    output alu_ctrl, reg_write, mem_read, mem_write, ir_load, pc_inc, pc_load,
           halted, illegal, bus_err
  );

  modport slave (
    output opcode, mem_ack, zero_flag,
    input  alu_ctrl, reg_write, mem_read, mem_write, ir_load, pc_inc, pc_load,
           halted, illegal, bus_err
  );
endinterface

// File: rtl/unitate_control_multiciclu.sv
// Multi-cycle RISC-8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a req/ack bus,
// with a memory-ack timeout and sticky HALT / ERR terminal states.
module unitate_control_multiciclu #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  unitate_control_multiciclu_if.master  bus
);
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [OPCODE_W-1:0]   OP_LOAD  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0]   OP_STORE = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0]   OP_BEQ   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0]   OP_JMP   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0]   OP_HALT  = OPCODE_W'(15);
  localparam logic [ALU_CTRL_W-1:0] ALU_IDLE = '1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cause_bus_q, cause_bus_d;

  logic [ALU_CTRL_W-1:0] alu_ctrl_c;
  logic                  reg_write_c, mem_read_c, mem_write_c, ir_load_c;
  logic                  pc_inc_c, pc_load_c, halted_c, illegal_c, bus_err_c;
  logic                  is_alu;

  assign is_alu = (opcode_q < OPCODE_W'(8));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      opcode_q    <= '0;
      cnt_q       <= '0;
      cause_bus_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      cnt_q       <= cnt_d;
      cause_bus_q <= cause_bus_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    cnt_d       = '0;
    cause_bus_d = cause_bus_q;
    alu_ctrl_c  = ALU_IDLE;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_load_c   = 1'b0;
    pc_inc_c    = 1'b0;
    pc_load_c   = 1'b0;
    halted_c    = 1'b0;
    illegal_c   = 1'b0;
    bus_err_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (bus.mem_ack) begin
          ir_load_c = 1'b1;
          pc_inc_c  = 1'b1;
          opcode_d  = bus.opcode;
          state_d   = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_ERR;
          cause_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_alu)                                        state_d = S_WB;
        else if (opcode_q == OP_LOAD || opcode_q == OP_STORE) state_d = S_MEM;
        else if (opcode_q == OP_BEQ)                       state_d = S_EXEC;
        else if (opcode_q == OP_JMP) begin
          pc_load_c = 1'b1;
          state_d   = S_FETCH;
        end
        else if (opcode_q == OP_HALT)                      state_d = S_HALT;
        else begin
          state_d     = S_ERR;
          cause_bus_d = 1'b0;
        end
      end
      S_EXEC: begin
        alu_ctrl_c = ALU_SUB;
        pc_load_c  = bus.zero_flag;
        state_d    = S_FETCH;
      end
      S_MEM: begin
        // Address add stays selected for the whole wait so the address is stable.
        alu_ctrl_c  = ALU_ADD;
        mem_read_c  = (opcode_q == OP_LOAD);
        mem_write_c = (opcode_q == OP_STORE);
        if (bus.mem_ack) begin
          state_d = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_ERR;
          cause_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        alu_ctrl_c  = is_alu ? ALU_CTRL_W'(opcode_q) : ALU_IDLE;
        state_d     = S_FETCH;
      end
      S_HALT:  halted_c = 1'b1;
      S_ERR: begin
        illegal_c = ~cause_bus_q;
        bus_err_c = cause_bus_q;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset is synchronous, so outputs are masked while rst is high to stop pulses leaking.
  always_comb begin
    bus.alu_ctrl  = rst ? ALU_IDLE : alu_ctrl_c;
    bus.reg_write = ~rst & reg_write_c;
    bus.mem_read  = ~rst & mem_read_c;
    bus.mem_write = ~rst & mem_write_c;
    bus.ir_load   = ~rst & ir_load_c;
    bus.pc_inc    = ~rst & pc_inc_c;
    bus.pc_load   = ~rst & pc_load_c;
    bus.halted    = ~rst & halted_c;
    bus.illegal   = ~rst & illegal_c;
    bus.bus_err   = ~rst & bus_err_c;
  end
endmodule

// File: tb/tb_unitate_control_multiciclu.sv
// Cycle-by-cycle check of the multi-cycle control unit: instruction table plus timeout,
// illegal/halt and mid-instruction reset sequences, expectations queued per driven cycle.
module tb_unitate_control_multiciclu;
  logic clk;
  logic rst;

  unitate_control_multiciclu_if #(.OPCODE_W(4), .ALU_CTRL_W(4)) bus ();

  unitate_control_multiciclu #(.OPCODE_W(4), .ALU_CTRL_W(4), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    int         fetch_wait;
    int         mem_wait;
    logic       zf;
  } instr_t;

  logic [12:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc_no = 0;

  // Packed order: alu_ctrl, reg_write, mem_read, mem_write, ir_load, pc_inc, pc_load,
  // halted, illegal, bus_err.
  function automatic logic [12:0] ev(logic [3:0] alu, logic rw, logic mr, logic mw,
                                     logic irl, logic pci, logic pcl,
                                     logic h, logic il, logic be);
    return {alu, rw, mr, mw, irl, pci, pcl, h, il, be};
  endfunction

  localparam logic [12:0] IDLE = 13'b1111_000000000;

  task automatic cyc(input string name, input logic r, input logic [3:0] op,
                     input logic ack, input logic zf, input logic [12:0] e);
    logic [12:0] got;
    logic [12:0] want;
    @(negedge clk);
    rst           = r;
    bus.opcode    = op;
    bus.mem_ack   = ack;
    bus.zero_flag = zf;
    exp_q.push_back(e);
    #1;
    got  = {bus.alu_ctrl, bus.reg_write, bus.mem_read, bus.mem_write, bus.ir_load,
            bus.pc_inc, bus.pc_load, bus.halted, bus.illegal, bus.bus_err};
    want = exp_q.pop_front();
    tests_run++;
    cyc_no++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %b required %b", name, cyc_no, got, want);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc("reset", 1'b1, 4'hA, 1'b1, 1'b1, IDLE);
  endtask

  task automatic fetch(input logic [3:0] op, input int fw);
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", 1'b0, 4'(i * 5), 1'b0, 1'b0, ev(4'hF,0,1,0,0,0,0,0,0,0));
    cyc("fetch_ack", 1'b0, op, 1'b1, 1'b0, ev(4'hF,0,1,0,1,1,0,0,0,0));
  endtask

  task automatic run_instr(input instr_t t);
    fetch(t.op, t.fetch_wait);
    // opcode and ack are garbled in DECODE to show they are not sampled here
    cyc("decode", 1'b0, ~t.op, 1'b1, 1'b1,
        (t.op == 4'd11) ? ev(4'hF,0,0,0,0,0,1,0,0,0) : IDLE);
    if (t.op < 4'd8) begin
      cyc("wb_alu", 1'b0, 4'h0, 1'b1, 1'b0, ev(t.op,1,0,0,0,0,0,0,0,0));
    end else if (t.op == 4'd8 || t.op == 4'd9) begin
      for (int i = 0; i <= t.mem_wait; i++)
        cyc("mem", 1'b0, 4'h0, (i == t.mem_wait), 1'b0,
            ev(4'h0,0,(t.op == 4'd8),(t.op == 4'd9),0,0,0,0,0,0));
      if (t.op == 4'd8)
        cyc("wb_load", 1'b0, 4'h0, 1'b1, 1'b0, ev(4'hF,1,0,0,0,0,0,0,0,0));
    end else if (t.op == 4'd10) begin
      cyc("beq_exec", 1'b0, 4'h0, 1'b1, t.zf, ev(4'h1,0,0,0,0,0,t.zf,0,0,0));
    end
  endtask

  instr_t tbl[14];

  initial begin
    rst = 1'b1;
    bus.opcode = '0;
    bus.mem_ack = 1'b0;
    bus.zero_flag = 1'b0;

    tbl[0]  = '{4'd2,  0, 0, 1'b0};
    tbl[1]  = '{4'd0,  1, 0, 1'b0};
    tbl[2]  = '{4'd7,  2, 0, 1'b0};
    tbl[3]  = '{4'd8,  0, 3, 1'b0};
    tbl[4]  = '{4'd9,  0, 0, 1'b0};
    tbl[5]  = '{4'd9,  1, 2, 1'b0};
    tbl[6]  = '{4'd10, 0, 0, 1'b1};
    tbl[7]  = '{4'd10, 1, 0, 1'b0};
    tbl[8]  = '{4'd11, 0, 0, 1'b0};
    tbl[9]  = '{4'd5,  0, 0, 1'b0};
    tbl[10] = '{4'd8,  0, 0, 1'b0};
    tbl[11] = '{4'd11, 3, 0, 1'b0};
    tbl[12] = '{4'd8,  14, 14, 1'b0};
    tbl[13] = '{4'd1,  0, 0, 1'b0};

    do_reset(2);
    for (int k = 0; k < 14; k++) begin
      run_instr(tbl[k]);
      $display("[TB] instr %0d op=%b fw=%0d mw=%0d zf=%0d done, failures so far %0d",
               k, tbl[k].op, tbl[k].fetch_wait, tbl[k].mem_wait, tbl[k].zf, tests_failed);
    end

    // Fetch timeout: 15 unacked cycles, then bus_err sticky with ack ignored.
    for (int i = 0; i < 15; i++)
      cyc("to_fetch_wait", 1'b0, 4'h2, 1'b0, 1'b0, ev(4'hF,0,1,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("to_fetch_err", 1'b0, 4'h2, 1'b1, 1'b0, ev(4'hF,0,0,0,0,0,0,0,0,1));
    $display("[TB] fetch timeout sequence done, failures so far %0d", tests_failed);

    // Store data-phase timeout.
    do_reset(1);
    fetch(4'd9, 0);
    cyc("decode", 1'b0, 4'h0, 1'b0, 1'b0, IDLE);
    for (int i = 0; i < 15; i++)
      cyc("to_mem_wait", 1'b0, 4'h0, 1'b0, 1'b0, ev(4'h0,0,0,1,0,0,0,0,0,0));
    cyc("to_mem_err", 1'b0, 4'h0, 1'b1, 1'b0, ev(4'hF,0,0,0,0,0,0,0,0,1));
    $display("[TB] store timeout sequence done, failures so far %0d", tests_failed);

    // Illegal opcodes, each followed by reset recovery.
    for (int c = 12; c <= 14; c++) begin
      do_reset(1);
      fetch(4'(c), 0);
      cyc("decode_ill", 1'b0, 4'h0, 1'b0, 1'b0, IDLE);
      for (int i = 0; i < 3; i++)
        cyc("illegal", 1'b0, 4'h0, 1'(i), 1'b0, ev(4'hF,0,0,0,0,0,0,0,1,0));
      $display("[TB] illegal op %0d sequence done, failures so far %0d", c, tests_failed);
    end

    // HALT, then reset resumes fetching.
    do_reset(1);
    fetch(4'd15, 0);
    cyc("decode_halt", 1'b0, 4'h0, 1'b0, 1'b0, IDLE);
    for (int i = 0; i < 3; i++)
      cyc("halted", 1'b0, 4'h0, 1'(i), 1'b0, ev(4'hF,0,0,0,0,0,0,1,0,0));
    do_reset(1);
    cyc("post_halt_fetch", 1'b0, 4'h0, 1'b0, 1'b0, ev(4'hF,0,1,0,0,0,0,0,0,0));
    $display("[TB] halt sequence done, failures so far %0d", tests_failed);

    // Reset during a STORE data wait aborts cleanly.
    fetch(4'd9, 0);
    cyc("decode", 1'b0, 4'h0, 1'b0, 1'b0, IDLE);
    cyc("mem_store", 1'b0, 4'h0, 1'b0, 1'b0, ev(4'h0,0,0,1,0,0,0,0,0,0));
    cyc("rst_mid", 1'b1, 4'h0, 1'b0, 1'b0, IDLE);
    cyc("rst_mid_ack", 1'b1, 4'h0, 1'b1, 1'b0, IDLE);
    cyc("post_rst_fetch", 1'b0, 4'h0, 1'b0, 1'b0, ev(4'hF,0,1,0,0,0,0,0,0,0));
    run_instr('{4'd3, 0, 0, 1'b0});
    $display("[TB] mid-store reset sequence done, failures so far %0d", tests_failed);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
